// File: rtl/fsm7_driver.sv
// Walks an external fsm_7 through a requested number of transitions and checks each step.
// Define FSM7_DRV_HOLD_CHECK_EN to add a negative (non-matching input) check after every step.
`timescale 1ns/1ps
module fsm7_driver #(
  parameter int NSTATES = 7,
  parameter int LAT     = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   steps,
  input  logic [3:0]         y,
  output logic [NSTATES-1:0] adv,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [3:0]         err_exp,
  output logic [3:0]         err_got,
  output logic [CNT_W-1:0]   remaining,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE, S_ERR, S_HOLD
  } state_t;

  localparam logic [3:0]         LAST    = 4'(NSTATES - 1);
  localparam logic [2:0]         LAT_M1  = 3'(LAT - 1);
  localparam logic [NSTATES-1:0] ONE_ADV = NSTATES'(1);
  localparam logic [CNT_W-1:0]   ONE_CNT = CNT_W'(1);

  state_t     state, state_nx;
  logic [3:0] exp_st;
  logic [2:0] wcnt;
  logic       zero_done;
  logic [3:0] nxt;
  logic       match;
  logic       accept;

  // Handshake: start is a one-cycle request with no ready; it is honoured only in IDLE
  // and silently dropped in every other state.
  assign accept = (state == S_IDLE) && start;
  assign nxt    = (exp_st == LAST) ? 4'd0 : exp_st + 4'd1;

`ifdef FSM7_DRV_HOLD_CHECK_EN
  logic       neg;
  logic [4:0] hsum;
  logic [3:0] hold_idx;
  assign hsum     = {1'b0, exp_st} + 5'd3;
  assign hold_idx = (hsum >= 5'(NSTATES)) ? 4'(hsum - 5'(NSTATES)) : hsum[3:0];
  // In the negative phase the FSM must not have moved.
  assign match    = neg ? (y == exp_st) : (y == nxt);
`else
  assign match    = (y == nxt);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && steps != '0) state_nx = S_DRIVE;
      S_DRIVE: state_nx = (LAT_M1 == 3'd0) ? S_CHECK : S_WAIT;
      S_WAIT:  if (wcnt <= 3'd1) state_nx = S_CHECK;
      S_CHECK: begin
        if (!match) state_nx = S_ERR;
`ifdef FSM7_DRV_HOLD_CHECK_EN
        else if (neg) state_nx = (remaining == '0) ? S_DONE : S_DRIVE;
        else          state_nx = S_HOLD;
`else
        else state_nx = (remaining == ONE_CNT) ? S_DONE : S_DRIVE;
`endif
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_ERR;
`ifdef FSM7_DRV_HOLD_CHECK_EN
      S_HOLD:  state_nx = (LAT_M1 == 3'd0) ? S_CHECK : S_WAIT;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_st    <= 4'd0;
      wcnt      <= 3'd0;
      remaining <= '0;
      err_exp   <= 4'd0;
      err_got   <= 4'd0;
      zero_done <= 1'b0;
`ifdef FSM7_DRV_HOLD_CHECK_EN
      neg       <= 1'b0;
`endif
    end else begin
      zero_done <= accept && (steps == '0);
      case (state)
        S_IDLE:  if (accept && steps != '0) remaining <= steps;
        S_DRIVE: wcnt <= LAT_M1;
        S_WAIT:  wcnt <= wcnt - 3'd1;
        S_CHECK: begin
`ifdef FSM7_DRV_HOLD_CHECK_EN
          if (neg) begin
            if (match) neg <= 1'b0;
            else begin
              err_exp <= exp_st;
              err_got <= y;
            end
          end else
`endif
          if (match) begin
            exp_st    <= nxt;
            remaining <= remaining - ONE_CNT;
          end else begin
            err_exp <= nxt;
            err_got <= y;
          end
        end
`ifdef FSM7_DRV_HOLD_CHECK_EN
        S_HOLD: begin
          neg  <= 1'b1;
          wcnt <= LAT_M1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    adv   = '0;
    busy  = 1'b0;
    done  = zero_done;
    error = 1'b0;
    case (state)
      S_DRIVE: begin
        adv  = ONE_ADV << exp_st;
        busy = 1'b1;
      end
      S_WAIT, S_CHECK: busy = 1'b1;
`ifdef FSM7_DRV_HOLD_CHECK_EN
      S_HOLD: begin
        adv  = ONE_ADV << hold_idx;
        busy = 1'b1;
      end
`endif
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: doc/fsm7_driver.md
Name: fsm7_driver

Overview:
- Stimulus/checker block sitting on the opposite side of the fsm_7 `main` interface.
- It drives the seven advance inputs i0..i6 of `main` and reads back its 4-bit state code y.
- On command it walks `main` through a requested number of state transitions and verifies each one.
- It reports done or error with the failing state captured.

Parameters:
- NSTATES, 7, number of states in the driven FSM; codes 0..NSTATES-1.
- LAT, 1, cycles from an advance pulse to y showing the new state; legal range 1..7.
- CNT_W, 8, width of the step counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; accepted only in IDLE.
- steps  input  CNT_W  number of transitions to drive; sampled on an accepted start.
- y  input  4  state code read back from the driven FSM.
- adv  output  NSTATES  advance vector to the FSM; bit k maps to input ik.
- busy  output  1  high from the cycle after an accepted start until DONE or ERR.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky; high in ERR.
- err_exp  output  4  expected state code at the failure.
- err_got  output  4  y value sampled at the failure.
- remaining  output  CNT_W  transitions still to drive.

Behaviour:
- FSM contract driven by this block:
  - `main` resets to state 0.
  - In state k, ik=1 moves it to (k+1) mod NSTATES.
  - All other inputs are ignored.
  - y is valid LAT cycles after the advance edge.
- Reset (reset=0, asynchronous): state IDLE; adv=0, busy=0, done=0, error=0, err_exp=0, err_got=0, remaining=0; internal expected state exp=0.
- States: IDLE, DRIVE, WAIT, CHECK, DONE, ERR.
- IDLE:
  - start=1 with steps!=0: load remaining=steps, go to DRIVE.
  - start=1 with steps=0: pulse done next cycle, stay IDLE, busy stays 0.
- DRIVE:
  - For exactly one cycle adv is one-hot at bit exp; all other cycles adv=0.
  - Load the wait counter with LAT-1, go to WAIT (or straight to CHECK when LAT=1).
- WAIT: decrement the wait counter; go to CHECK at 0.
- CHECK compares y against nxt = (exp+1 == NSTATES) ? 0 : exp+1; the wrap 6->0 is mandatory.
  - Match: exp<=nxt, remaining<=remaining-1. If remaining was 1, go to DONE; otherwise go to DRIVE.
  - Mismatch: err_exp<=nxt, err_got<=y, go to ERR.
- DONE: done=1 for one cycle, busy=0, return to IDLE; exp is retained across commands.
- ERR: error=1, busy=0, adv=0. Exit only via reset; start is ignored.
- start while busy: ignored, with no effect on steps, remaining or state.
- Back-to-back commands: start in the same cycle done pulses is ignored (state is DONE, not IDLE); the next cycle accepts it.
- Reset mid-walk: all outputs return to reset values immediately and exp=0, matching the FSM's own reset.
- Timing: per-transition cost is LAT+1 cycles. Total from start to done is 1 + steps*(LAT+1) + 1 cycles.
- remaining never underflows; it is 0 in IDLE after DONE.

Optional Feature:
- FSM7_DRV_HOLD_CHECK_EN: adds a negative check after each successful CHECK.
  - A state HOLD drives adv one-hot at bit (exp+3) mod NSTATES, i.e. a non-matching input, for one cycle.
  - It then waits LAT cycles and requires y==exp.
  - A mismatch sets err_exp=exp, err_got=y and enters ERR.
  - Per-transition cost becomes 2*LAT+2 cycles.
- Without the macro: no HOLD state and no non-matching drive; timing is as above.

Test Plan:
- Reset, start with steps=3, correct FSM model, LAT=1 -> adv pulses 0x01, 0x02, 0x04 on separate cycles; done pulses at cycle 8 after start; remaining=0; exp=3.
- steps=10 from exp=0 -> wraps 6->0; y sequence 1,2,3,4,5,6,0,1,2,3; done with no error; final exp=3.
- FSM model stuck at 2, steps=5 -> error=1, err_exp=3, err_got=2, busy=0, adv=0 thereafter; a later start is ignored.
- start with steps=0 -> done pulse next cycle, no adv activity; start pulsed during a steps=4 walk -> ignored, exactly 4 transitions.
- Assert reset mid-walk at remaining=2 -> all outputs return to 0 asynchronously (before the next clock edge); a fresh start with steps=1 drives adv=0x01.
- With FSM7_DRV_HOLD_CHECK_EN, model advancing on any input, steps=1 -> pass on CHECK, then HOLD drives adv=0x10 (exp=1, bit 4); y becomes 2 -> error, err_exp=1, err_got=2.
